// File: rtl/regfile_sequencer_pkg.sv
// Shared types and regfile command codes for the regfile command sequencer.
package regfile_sequencer_pkg;

    localparam int REGISTERS   = 8;
    localparam int INDEX_WIDTH = $clog2(REGISTERS);
    localparam int COM_WIDTH   = 4;
    localparam int SEL_WIDTH   = 3 * INDEX_WIDTH;

    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_MOV   = 2'd1,
        OP_SPINC = 2'd2,
        OP_SPDEC = 2'd3
    } op_kind_t;

    localparam logic [COM_WIDTH-1:0] COM_NOP      = 4'h0;
    localparam logic [COM_WIDTH-1:0] COM_READA    = 4'h1;
    localparam logic [COM_WIDTH-1:0] COM_READB    = 4'h2;
    localparam logic [COM_WIDTH-1:0] COM_LATCHC   = 4'h3;
    localparam logic [COM_WIDTH-1:0] COM_LATCHSEL = 4'h4;
    localparam logic [COM_WIDTH-1:0] COM_SP_INC   = 4'h7;
    localparam logic [COM_WIDTH-1:0] COM_SP_DEC   = 4'h8;
    localparam logic [COM_WIDTH-1:0] COM_LATCHF   = 4'hA;

    // Packed select layout consumed by the regfile: {sel_c, sel_b, sel_a}.
    function automatic logic [SEL_WIDTH-1:0] pack_sel(
        input logic [INDEX_WIDTH-1:0] sel_c,
        input logic [INDEX_WIDTH-1:0] sel_b,
        input logic [INDEX_WIDTH-1:0] sel_a
    );
        return {sel_c, sel_b, sel_a};
    endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Op request / ALU handshake and regfile command bus of the sequencer.
interface regfile_sequencer_if;
    import regfile_sequencer_pkg::*;

    logic                   i_op_valid;
    logic                   o_op_ready;
    op_kind_t               i_op_kind;
    logic [INDEX_WIDTH-1:0] i_sel_a;
    logic [INDEX_WIDTH-1:0] i_sel_b;
    logic [INDEX_WIDTH-1:0] i_sel_c;
    logic                   i_write_f;
    logic                   i_alu_valid;
    logic [COM_WIDTH-1:0]   o_com;
    logic [SEL_WIDTH-1:0]   o_sel;
    logic                   o_done;
    logic                   o_error;

    modport master (
        output i_op_valid, i_op_kind, i_sel_a, i_sel_b, i_sel_c, i_write_f, i_alu_valid,
        input  o_op_ready, o_com, o_sel, o_done, o_error
    );

    modport slave (
        input  i_op_valid, i_op_kind, i_sel_a, i_sel_b, i_sel_c, i_write_f, i_alu_valid,
        output o_op_ready, o_com, o_sel, o_done, o_error
    );

endinterface

// File: rtl/regfile_sequencer_watchdog.sv
// ALU-wait watchdog: counts wait cycles from start and flags the last permitted one.
module regseq_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle counter, cleared on wait entry and saturating at the last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (start) begin
            count_r <= '0;
        end else if (tick && (count_r != LAST_COUNT)) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign expired = (count_r == LAST_COUNT);

endmodule

// File: rtl/regfile_sequencer.sv
// Regfile command sequencer: turns one accepted register-level op into a per-cycle COM_* stream.
// Build option REGSEQ_TIMEOUT_EN adds an ALU-wait timeout that aborts the op with an o_error pulse.
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    regfile_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_RDA  = 3'd2,
        S_RDB  = 3'd3,
        S_WAIT = 3'd4,
        S_WRC  = 3'd5,
        S_WRF  = 3'd6,
        S_SP   = 3'd7
    } state_t;

    state_t                 state_r, state_next_s;
    op_kind_t               kind_r, kind_next_s;
    logic                   write_f_r, write_f_next_s;
    logic [SEL_WIDTH-1:0]   sel_r, sel_next_s;
    logic [COM_WIDTH-1:0]   com_r, com_next_s;
    logic                   done_r, done_next_s;
    logic                   ready_r;
    logic                   timeout_s;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef REGSEQ_TIMEOUT_EN
    logic wd_start_s;
    logic wd_tick_s;
    logic wd_expired_s;
    logic error_r;

    assign wd_start_s = (state_next_s == S_WAIT) && (state_r != S_WAIT);
    assign wd_tick_s  = (state_r == S_WAIT);
    // A result arriving on the expiry cycle still wins over the abort.
    assign timeout_s  = (state_r == S_WAIT) && wd_expired_s && !bus.i_alu_valid;

    regseq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (i_clk),
        .rst     (i_reset),
        .start   (wd_start_s),
        .tick    (wd_tick_s),
        .expired (wd_expired_s)
    );

    // Error pulse register, set for one cycle when the ALU wait is abandoned.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            error_r <= 1'b0;
        end else begin
            error_r <= timeout_s;
        end
    end

    assign bus.o_error = error_r;
`else
    assign timeout_s   = 1'b0;
    assign bus.o_error = 1'b0;
`endif

    // Next-state logic; op fields are captured only on the accepting edge.
    always_comb begin
        state_next_s   = state_r;
        kind_next_s    = kind_r;
        write_f_next_s = write_f_r;
        sel_next_s     = sel_r;
        case (state_r)
            S_IDLE: begin
                if (bus.i_op_valid) begin
                    kind_next_s    = bus.i_op_kind;
                    write_f_next_s = bus.i_write_f;
                    sel_next_s     = pack_sel(bus.i_sel_c, bus.i_sel_b, bus.i_sel_a);
                    state_next_s   = ((bus.i_op_kind == OP_SPINC) || (bus.i_op_kind == OP_SPDEC))
                                     ? S_SP : S_SEL;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_SEL:  state_next_s = S_RDA;
            S_RDA:  state_next_s = (kind_r == OP_MOV) ? S_WRC : S_RDB;
            S_RDB:  state_next_s = S_WAIT;
            S_WAIT: begin
                if (bus.i_alu_valid) begin
                    state_next_s = S_WRC;
                end else if (timeout_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_WRC:  state_next_s = ((kind_r == OP_ALU) && write_f_r) ? S_WRF : S_IDLE;
            S_WRF:  state_next_s = S_IDLE;
            S_SP:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Command decode of the upcoming state, so the outputs can be registered without extra latency.
    always_comb begin
        com_next_s  = COM_NOP;
        done_next_s = 1'b0;
        case (state_next_s)
            S_IDLE: com_next_s = COM_NOP;
            S_SEL:  com_next_s = COM_LATCHSEL;
            S_RDA:  com_next_s = COM_READA;
            S_RDB:  com_next_s = COM_READB;
            S_WAIT: com_next_s = COM_NOP;
            S_WRC: begin
                com_next_s  = COM_LATCHC;
                done_next_s = !((kind_next_s == OP_ALU) && write_f_next_s);
            end
            S_WRF: begin
                com_next_s  = COM_LATCHF;
                done_next_s = 1'b1;
            end
            S_SP: begin
                com_next_s  = (kind_next_s == OP_SPINC) ? COM_SP_INC : COM_SP_DEC;
                done_next_s = 1'b1;
            end
            default: com_next_s = COM_NOP;
        endcase
    end

    // FSM state and captured op fields.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r   <= S_IDLE;
            kind_r    <= OP_ALU;
            write_f_r <= 1'b0;
            sel_r     <= '0;
        end else begin
            state_r   <= state_next_s;
            kind_r    <= kind_next_s;
            write_f_r <= write_f_next_s;
            sel_r     <= sel_next_s;
        end
    end

    // Registered command outputs; reset drops any in-flight command at once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            com_r   <= COM_NOP;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            com_r   <= com_next_s;
            done_r  <= done_next_s;
            ready_r <= (state_next_s == S_IDLE);
        end
    end

    assign bus.o_com      = com_r;
    assign bus.o_sel      = sel_r;
    assign bus.o_done     = done_r;
    assign bus.o_op_ready = ready_r;

endmodule
